// File: rtl/instr_mem_fetch_if.sv
// Loader and fetch handshake bundle for instr_mem_fetch.
// slave is the memory block; master is the loader/IF-stage side.
interface instr_mem_fetch_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PC_W   = 32
);
    logic              load_start;
    logic              load_valid;
    logic [XLEN-1:0]   load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              load_ovf;
    logic              fetch_req_valid;
    logic              fetch_req_ready;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_rsp_valid;
    logic              fetch_rsp_ready;
    logic [XLEN-1:0]   fetch_instr;
    logic [PC_W-1:0]   fetch_pc_out;
    logic [1:0]        fetch_fault;
    logic [ADDR_W:0]   words_loaded;

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req_valid, fetch_pc, fetch_rsp_ready,
        output load_ready, load_done, load_ovf, fetch_req_ready,
        output fetch_rsp_valid, fetch_instr, fetch_pc_out, fetch_fault, words_loaded
    );

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req_valid, fetch_pc, fetch_rsp_ready,
        input  load_ready, load_done, load_ovf, fetch_req_ready,
        input  fetch_rsp_valid, fetch_instr, fetch_pc_out, fetch_fault, words_loaded
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a one-cycle registered fetch port.
// Word-serial loader fills the array from word 0; fetch is enabled only once a load completes.
module instr_mem_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 1024,
    parameter int unsigned     ADDR_W   = 10,
    parameter int unsigned     PC_W     = 32,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
    input logic              clk,
    input logic              reset,
    instr_mem_fetch_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   rdata_q;
    logic              hit_q;

    logic              wr_en;
    logic              last_slot;
    logic              accept;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        fault_d;

    always_comb begin
        wr_en     = bus.load_valid && bus.load_ready && !reset;
        last_slot = (wptr_q == ADDR_W'(DEPTH - 1));
        bus.load_ready      = (state_q == StLoad) && !bus.load_start;
        bus.fetch_req_ready = (state_q == StRun) && !bus.load_start &&
                              (!bus.fetch_rsp_valid || bus.fetch_rsp_ready);
        accept  = bus.fetch_req_valid && bus.fetch_req_ready;
        idx     = bus.fetch_pc[ADDR_W+1:2];
        fault_d = 2'b00;
        if (bus.fetch_pc[1:0] != 2'b00) begin
            fault_d = 2'b01;
        end else if (bus.fetch_pc[PC_W-1:ADDR_W+2] != '0) begin
            fault_d = 2'b10;
        end else if ({1'b0, idx} >= bus.words_loaded) begin
            fault_d = 2'b11;
        end
        // RAM output is unreset, so the NOP substitution sits after the read register.
        bus.fetch_instr = hit_q ? rdata_q : NOP_WORD;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= bus.load_data;
        end
        if (accept) begin
            rdata_q <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= StIdle;
            wptr_q              <= '0;
            bus.words_loaded    <= '0;
            bus.load_done       <= 1'b0;
            bus.load_ovf        <= 1'b0;
            bus.fetch_rsp_valid <= 1'b0;
            bus.fetch_pc_out    <= '0;
            bus.fetch_fault     <= 2'b00;
            hit_q               <= 1'b0;
        end else begin
            bus.load_done <= 1'b0;
            unique case (state_q)
                StIdle, StRun: begin
                    if (bus.load_start) begin
                        state_q          <= StLoad;
                        wptr_q           <= '0;
                        bus.words_loaded <= '0;
                        bus.load_ovf     <= 1'b0;
                    end
                end
                StLoad: begin
                    if (bus.load_start) begin
                        wptr_q           <= '0;
                        bus.words_loaded <= '0;
                        bus.load_ovf     <= 1'b0;
                    end else if (wr_en) begin
                        wptr_q <= wptr_q + 1'b1;
                        if (bus.load_last) begin
                            bus.words_loaded <= {1'b0, wptr_q} + 1'b1;
                            bus.load_done    <= 1'b1;
                            state_q          <= StRun;
                        end else if (last_slot) begin
                            bus.words_loaded <= (ADDR_W + 1)'(DEPTH);
                            bus.load_ovf     <= 1'b1;
                            bus.load_done    <= 1'b1;
                            state_q          <= StRun;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                bus.fetch_rsp_valid <= 1'b1;
                bus.fetch_pc_out    <= bus.fetch_pc;
                bus.fetch_fault     <= fault_d;
                hit_q               <= (fault_d == 2'b00);
            end else if (bus.fetch_rsp_ready) begin
                bus.fetch_rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, loadable instruction memory with a registered fetch port and valid/ready handshakes. A word-serial loader port programs the memory at run time, so no initial block is needed. The CPU fetch stage presents a byte-address PC and receives the instruction one cycle later, together with a fault code. The block sits between the program loader (test harness or host) and the IF stage of the single-cycle/pipelined RISC-V core.

Parameters:
XLEN, 32, instruction word width in bits
DEPTH, 1024, number of instruction words
ADDR_W, 10, word-index width; equals log2(DEPTH)
PC_W, 32, fetch PC width, byte address
NOP_WORD, 32'h0000_0013, word returned on fault (addi x0,x0,0)

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse that begins a program load at word 0
load_valid  in  1  load_data holds a valid word
load_data  in  XLEN  instruction word to write
load_last  in  1  qualifies the final word of the load
load_ready  out  1  loader may transfer a word this cycle
load_done  out  1  one-cycle pulse when a load completes
load_ovf  out  1  sticky flag: load was truncated at DEPTH; cleared by reset or load_start
fetch_req_valid  in  1  fetch request valid
fetch_req_ready  out  1  block accepts a request this cycle
fetch_pc  in  PC_W  byte-address PC of the request
fetch_rsp_valid  out  1  response valid
fetch_rsp_ready  in  1  IF stage consumes the response
fetch_instr  out  XLEN  fetched instruction
fetch_pc_out  out  PC_W  PC that belongs to fetch_instr
fetch_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 unloaded
words_loaded  out  ADDR_W+1  count of valid words, 0..DEPTH

Behaviour:
- Reset values: state=IDLE, load_ready=0, load_done=0, load_ovf=0, fetch_req_ready=0, fetch_rsp_valid=0, fetch_instr=NOP_WORD, fetch_pc_out=0, fetch_fault=00, words_loaded=0. Memory array contents are not reset.
- States:
  - IDLE: waiting for a program. load_start -> LOAD. Fetch requests are refused (req_ready=0).
  - LOAD: load_ready=1. Each load_valid&&load_ready writes load_data to mem[wptr], then wptr++.
    - On load_valid&&load_last: words_loaded<=wptr+1, load_done pulses the next cycle, state -> RUN.
    - On a write at wptr=DEPTH-1 without load_last: words_loaded<=DEPTH, load_ovf<=1, load_done pulses, state -> RUN. Further load words are not accepted.
  - RUN: fetch is enabled. load_start -> LOAD, with wptr=0, words_loaded=0 and load_ovf=0 on the next edge. fetch_req_ready drops in that same cycle (combinational on load_start). A response already held stays valid until it is consumed.
- load_start in LOAD restarts the load: wptr=0 and the accepted count is discarded.
- fetch_req_ready = (state==RUN) && !load_start && (!fetch_rsp_valid || fetch_rsp_ready).
- Fetch latency: a request accepted at edge N gives fetch_rsp_valid=1 after edge N, i.e. one-cycle synchronous read. Back-to-back requests with rsp_ready held high give one response per cycle.
- Response registers hold stable while fetch_rsp_valid && !fetch_rsp_ready.
- fetch_rsp_valid clears on consume when there is no new accept in the same cycle.
- Address and fault decode, priority high to low, with idx = fetch_pc[ADDR_W+1:2]:
  - fetch_pc[1:0]!=0 -> fault 01.
  - fetch_pc >= DEPTH*4 -> fault 10.
  - idx >= words_loaded -> fault 11.
  - Otherwise fault 00 and instr=mem[idx].
  - Any fault returns instr=NOP_WORD. fetch_pc_out always equals the accepted PC.
- Simultaneous fetch accept and load write cannot occur, because loads happen only outside RUN.
- Reset mid-load or mid-fetch: everything returns to reset values on the next edge. The pending response is dropped, the memory keeps its data, and words_loaded=0, so a reload is required.
- Read and write use separate ports (simple dual-port), so the array maps to block RAM.

Test Plan:
- Reset, then fetch_req_valid=1 at pc 0 -> fetch_req_ready stays 0 and no response is produced. After load_start, load 3 words (0x00100513, 0x00150593, 0x00250613, last on the 3rd) -> load_done pulses once, words_loaded=3.
- Back-to-back fetch of pc 0,4,8 with rsp_ready=1 -> responses on 3 consecutive cycles with the loaded words in order, fault 00, and fetch_pc_out 0,4,8.
- Fetch pc 12 after the 3-word load -> instr 0x00000013, fault 11. Fetch pc 6 -> fault 01. Fetch pc 4096 with DEPTH=1024 -> fault 10.
- Backpressure: rsp_ready=0 for 4 cycles after a response -> fetch_instr and fetch_pc_out hold stable and req_ready=0. When rsp_ready rises, the next request is accepted in the same cycle.
- Overflow: DEPTH=8, stream 10 words without load_last -> 8 words written, load_ovf=1, words_loaded=8, load_ready=0 after the 8th word. Fetch pc 28 returns the 8th word.
- Reset asserted during a load after word 2 -> next cycle state IDLE and words_loaded=0. Reload of 1 word then a fetch at pc 0 -> new word, fault 00.
